// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and baud divisor helper for the CPLD UART responder
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic int unsigned UART_DIV(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - THR handoff, 8N1 shifter and TX FSM with tbre/tsre status
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_i,
    input  logic [7:0] data_i,
    output logic       tbre_o,
    output logic       tsre_o,
    output logic       txd_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  thr_q, thr_d;
    logic        tbre_q, tbre_d;
    logic        tsre_q, tsre_d;
    logic        txd_q, txd_d;
    logic        load;
    logic        accept;
    logic        bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            thr_q   <= '0;
            tbre_q  <= 1'b1;
            tsre_q  <= 1'b1;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            thr_q   <= thr_d;
            tbre_q  <= tbre_d;
            tsre_q  <= tsre_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        thr_d   = thr_q;
        tsre_d  = tsre_q;
        txd_d   = txd_q;
        load    = 1'b0;
        bit_end = (cnt_q == CNT_MAX);
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!tbre_q) load = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    txd_d   = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!tbre_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                        tsre_d  = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // The transfer frees THR on this edge, so a coincident write still lands.
        if (load) begin
            shift_d = thr_q;
            state_d = TX_START;
            cnt_d   = '0;
            txd_d   = 1'b0;
            tsre_d  = 1'b0;
        end

        accept = wr_i && (tbre_q || load);
        if (accept) thr_d = data_i;
        tbre_d = accept ? 1'b0 : (load ? 1'b1 : tbre_q);
    end

    assign tbre_o = tbre_q;
    assign tsre_o = tsre_q;
    assign txd_o  = txd_q;

endmodule

// File: rtl/cpld_uart_responder.sv
// rtl/cpld_uart_responder.sv - CPLD serial controller emulation: strobe bus, RX path, RBR
module cpld_uart_responder
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rdn,
    input  logic       uart_wrn,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    output logic       rx_overrun,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned DIV = UART_DIV(CLK_HZ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(DIV / 2 - 1);

    // [1:0] synchronize, [2] holds the previous synchronized value for edge detection.
    logic [2:0] rdn_q, wrn_q, rx_q;
    logic       rd_rise, wr_fall, rx_fall, rx_bit;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rbr_q, rbr_d;
    logic          dr_q, dr_d;
    logic          ov_q, ov_d;
    logic          done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q      <= 3'b111;
            wrn_q      <= 3'b111;
            rx_q       <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rbr_q      <= '0;
            dr_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            rdn_q      <= {rdn_q[1:0], uart_rdn};
            wrn_q      <= {wrn_q[1:0], uart_wrn};
            rx_q       <= {rx_q[1:0], rxd};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rbr_q      <= rbr_d;
            dr_q       <= dr_d;
            ov_q       <= ov_d;
        end
    end

    assign rd_rise = rdn_q[1] & ~rdn_q[2];
    assign wr_fall = ~wrn_q[1] & wrn_q[2];
    assign rx_fall = ~rx_q[1] & rx_q[2];
    assign rx_bit  = rx_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        done       = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_MAX) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_MAX) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_bit, rx_sh_q[7:1]};
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_MAX) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    done       = rx_bit;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A frame completing on the read-clear edge takes priority over the clear.
    always_comb begin
        rbr_d = rbr_q;
        dr_d  = dr_q;
        ov_d  = ov_q;
        if (rd_rise) begin
            dr_d = 1'b0;
            ov_d = 1'b0;
        end
        if (done) begin
            if (!dr_q || rd_rise) begin
                rbr_d = rx_sh_q;
                dr_d  = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    uart_tx_serializer #(
        .DIV (DIV)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst),
        .wr_i   (wr_fall),
        .data_i (data_i),
        .tbre_o (uart_tbre),
        .tsre_o (uart_tsre),
        .txd_o  (txd)
    );

    assign data_o         = rbr_q;
    assign data_oe        = rst & ~uart_rdn;
    assign uart_dataready = dr_q;
    assign rx_overrun     = ov_q;

endmodule
